// File: rtl/sel_stream_fifo.sv
// sel_stream_fifo: show-ahead synchronous FIFO with occupancy count and
// high-water mark. Sits behind the 3-bit mux stage and buffers its words.
// DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
module sel_stream_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     hwm
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    hwm_q, hwm_d;
    logic             push, pop;

    // Handshakes come from registered occupancy only, so there is no
    // combinational path from in_valid/out_ready to the ready/valid outputs.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head entry is presented directly (show-ahead); don't-care when empty.
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign hwm       = hwm_q;

    // Next-state: pointers wrap naturally at DEPTH, count tracks push/pop
    // imbalance, hwm follows the peak of the upcoming count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
    end

    // Control state; reset wins over any push/pop in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hwm_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hwm_q    <= hwm_d;
        end
    end

    // Storage is never cleared; a write during reset is suppressed so the
    // reset cycle has no visible side effect.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: tb/tb_sel_stream_fifo.sv
// Bench for sel_stream_fifo: directed scenarios plus a randomized run,
// all compared against a queue-based FIFO model.
module tb_sel_stream_fifo;

    localparam int WIDTH = 3;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic [CW-1:0]    hwm;

    int tests_run = 0;
    int failed    = 0;

    // Reference model: queue of stored words plus peak occupancy.
    int q[$];
    int m_hwm = 0;

    sel_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .hwm(hwm)
    );

    always #5 clk = ~clk;

    // Advance one clock, apply the FIFO rules to the model, settle 1ns.
    task automatic cycle();
        bit mpush, mpop;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_hwm = 0;
        end else begin
            mpush = in_valid && (q.size() < DEPTH);
            mpop  = out_ready && (q.size() > 0);
            if (mpop)  void'(q.pop_front());
            if (mpush) q.push_back(int'(in_data));
            if (q.size() > m_hwm) m_hwm = q.size();
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        tests_run++;
        if (count !== 0) begin failed++; $display("FAIL reset_count got %0d want 0", count); end
        tests_run++;
        if (hwm !== 0) begin failed++; $display("FAIL reset_hwm got %0d want 0", hwm); end
        tests_run++;
        if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests_run++;
        if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_fill();
        logic [WIDTH-1:0] words [4];
        words[0] = 3'b001; words[1] = 3'b010; words[2] = 3'b011; words[3] = 3'b100;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            cycle();
            tests_run++;
            if (count !== CW'(i + 1)) begin failed++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
        end
        tests_run++;
        if (in_ready !== 1'b0) begin failed++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
        tests_run++;
        if (hwm !== 4) begin failed++; $display("FAIL fill_hwm got %0d want 4", hwm); end
        tests_run++;
        if (out_data !== 3'b001) begin failed++; $display("FAIL fill_head got %b want 001", out_data); end
        // Fifth push while full must be ignored.
        in_data = 3'b111;
        cycle();
        in_valid = 1'b0;
        tests_run++;
        if (count !== 4) begin failed++; $display("FAIL overfill_count got %0d want 4", count); end
        tests_run++;
        if (out_data !== 3'b001) begin failed++; $display("FAIL overfill_head got %b want 001", out_data); end
    endtask

    task automatic test_drain();
        logic [WIDTH-1:0] words [4];
        words[0] = 3'b001; words[1] = 3'b010; words[2] = 3'b011; words[3] = 3'b100;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (out_data !== words[i] || out_valid !== 1'b1) begin
                failed++;
                $display("FAIL drain_word[%0d] got %b (valid %b) want %b", i, out_data, out_valid, words[i]);
            end
            cycle();
        end
        out_ready = 1'b0;
        tests_run++;
        if (count !== 0) begin failed++; $display("FAIL drain_count got %0d want 0", count); end
        tests_run++;
        if (out_valid !== 1'b0) begin failed++; $display("FAIL drain_out_valid got %b want 0", out_valid); end
        tests_run++;
        if (hwm !== 4) begin failed++; $display("FAIL drain_hwm got %0d want 4", hwm); end
    endtask

    task automatic test_wrap();
        test_reset();
        in_valid = 1'b1;
        in_data  = 3'b101;
        cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = WIDTH'(i % 8);
            tests_run++;
            if (q.size() == 0 || out_data !== WIDTH'(q[0])) begin
                failed++;
                $display("FAIL wrap_word[%0d] got %b want %0d", i, out_data, (q.size() > 0) ? q[0] : -1);
            end
            cycle();
            tests_run++;
            if (count !== 1) begin failed++; $display("FAIL wrap_count[%0d] got %0d want 1", i, count); end
        end
        idle_inputs();
        tests_run++;
        if (hwm > 2 || hwm !== CW'(m_hwm)) begin failed++; $display("FAIL wrap_hwm got %0d want %0d", hwm, m_hwm); end
        tests_run++;
        if (out_data !== 3'b001) begin failed++; $display("FAIL wrap_last got %b want 001", out_data); end
    endtask

    task automatic test_full_pop();
        test_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = WIDTH'($urandom_range(0, 7));
            cycle();
        end
        out_ready = 1'b1;
        in_data   = 3'b110;
        tests_run++;
        if (in_ready !== 1'b0) begin failed++; $display("FAIL fullpop_in_ready got %b want 0", in_ready); end
        cycle();
        tests_run++;
        if (count !== 3) begin failed++; $display("FAIL fullpop_count got %0d want 3", count); end
        out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        tests_run++;
        if (count !== 4) begin failed++; $display("FAIL fullpop_refill got %0d want 4", count); end
        // Drain and confirm order against the model, including the late 110.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (out_data !== WIDTH'(q[0])) begin failed++; $display("FAIL fullpop_order[%0d] got %b want %0d", i, out_data, q[0]); end
            cycle();
        end
        tests_run++;
        if (q.size() != 0 || count !== 0) begin failed++; $display("FAIL fullpop_drained got %0d want 0", count); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        test_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = WIDTH'(i + 1);
            cycle();
        end
        // Reset with push and pop both requested: both must be ignored.
        rst_n     = 1'b0;
        in_data   = 3'b111;
        out_ready = 1'b1;
        cycle();
        rst_n = 1'b1;
        idle_inputs();
        tests_run++;
        if (count !== 0) begin failed++; $display("FAIL midrst_count got %0d want 0", count); end
        tests_run++;
        if (hwm !== 0) begin failed++; $display("FAIL midrst_hwm got %0d want 0", hwm); end
        tests_run++;
        if (out_valid !== 1'b0) begin failed++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        in_valid = 1'b1;
        in_data  = 3'b110;
        cycle();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 3'b110 || count !== 1) begin
            failed++;
            $display("FAIL midrst_newword got %b valid %b count %0d want 110 1 1", out_data, out_valid, count);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        test_reset();
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 45);
            in_data   = WIDTH'($urandom_range(0, 7));
            cycle();
            tests_run++;
            if (count !== CW'(q.size()) || hwm !== CW'(m_hwm)
                || in_ready !== (q.size() != DEPTH) || out_valid !== (q.size() != 0)
                || (q.size() != 0 && out_data !== WIDTH'(q[0]))) begin
                failed++;
                errs++;
                if (errs < 10)
                    $display("FAIL rand[%0d] count %0d/%0d hwm %0d/%0d rdy %b vld %b data %b head %0d",
                             i, count, q.size(), hwm, m_hwm, in_ready, out_valid, out_data,
                             (q.size() != 0) ? q[0] : -1);
            end
        end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/sel_stream_fifo.md
SEL_STREAM_FIFO -- requirements
Module: sel_stream_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the data word width; it matches the 3-bit mux output it consumes.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of entries; DEPTH SHALL be a power of two and at least 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port in_data, input, WIDTH bits: upstream word, connected to the mux stage output out1.
REQ-006 Port in_valid, input, 1 bit: in_data holds a word to be written.
REQ-007 Port in_ready, output, 1 bit: the FIFO can accept a word this cycle.
REQ-008 Port out_data, output, WIDTH bits: the word at the FIFO head.
REQ-009 Port out_valid, output, 1 bit: out_data is valid.
REQ-010 Port out_ready, input, 1 bit: downstream accepts out_data this cycle.
REQ-011 Port count, output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-012 Port hwm, output, $clog2(DEPTH)+1 bits: peak occupancy reached since reset.

Function
REQ-013 The push condition SHALL be in_valid && in_ready; the pop condition SHALL be out_valid && out_ready.
REQ-014 in_ready SHALL equal (count != DEPTH); out_valid SHALL equal (count != 0); both derive from registered state only, with no combinational path from in_valid or out_ready.
REQ-015 out_data SHALL be combinational from the head entry (show-ahead), so the first written word is visible the cycle after its push edge.
REQ-016 On a push, in_data SHALL be written at the write pointer, and the write pointer SHALL advance modulo DEPTH (wrap from DEPTH-1 to 0).
REQ-017 On a pop, the read pointer SHALL advance modulo DEPTH.
REQ-018 count SHALL update as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or when neither occurs.
REQ-019 When full, in_ready SHALL be 0, so a pop in that cycle SHALL leave count at DEPTH-1 and no word SHALL be lost or overwritten.
REQ-020 When empty, out_valid SHALL be 0; a push in that cycle SHALL make count 1 and out_valid 1 on the next cycle, with no same-cycle bypass.
REQ-021 Simultaneous push and pop at 0 < count < DEPTH SHALL preserve word order and keep count constant.
REQ-022 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-023 Words SHALL leave the FIFO in strict arrival order, with no duplication or loss.
REQ-024 hwm SHALL register max(hwm, next count) every cycle and never decrease except on reset.
REQ-025 in_valid asserted while in_ready=0 SHALL have no effect on state.

Reset
REQ-026 When rst_n=0 at a rising clk edge, the block SHALL clear both pointers, count and hwm to 0.
REQ-027 After such a reset edge, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-028 Storage contents SHALL NOT need clearing, and out_data is don't-care while out_valid=0.
REQ-029 A reset asserted mid-operation SHALL discard all stored words, and any push or pop in that cycle SHALL be ignored.

Verification
REQ-030 Reset then idle: hold rst_n=0 for 2 cycles, then release -> count=0, hwm=0, in_ready=1, out_valid=0.
REQ-031 Fill with out_ready=0: push 3'b001, 3'b010, 3'b011, 3'b100 -> count=4, in_ready=0, hwm=4, out_data=3'b001; a fifth push of 3'b111 is ignored.
REQ-032 Drain from full: set out_ready=1 for 4 cycles -> outputs are 001, 010, 011, 100 in order, then count=0, out_valid=0, hwm stays 4.
REQ-033 Wrap-around: run continuous push and pop of 3'b000..3'b111 repeated over 10 words at count=1 -> count stays 1, order is preserved across the pointer wrap, hwm=2 or less.
REQ-034 Full plus simultaneous pop: at count=4, with in_valid=1 and out_ready=1 -> the pop occurs, the push is refused, count=3; the next cycle the push is accepted and count=4.
REQ-035 Reset mid-stream: at count=3, drive rst_n=0 for 1 cycle -> count=0, hwm=0, out_valid=0, and the old words never appear on out_data.
